// File: rtl/vga_console_writer.sv
// vga_console_writer: byte-stream text console driving the 40x30 VRAM write port.
// Define VGA_CONSOLE_TAB_EN to make HT (0x09) advance to the next 8-column tab stop.
module vga_console_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int AW = 11,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          char_valid,
  input  logic [7:0]    char_data,
  output logic          char_ready,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic [5:0]    cur_col,
  output logic [4:0]    cur_row
);
  typedef enum logic [1:0] {IDLE, CLEAR, CLRLINE} state_t;
  localparam logic [AW-1:0] LAST_ALL = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);
  state_t r_state, w_state;
  logic [AW-1:0] r_addr, w_addr, r_cnt, w_cnt, r_waddr, w_waddr;
  logic [7:0] r_wdata, w_wdata;
  logic r_we, w_we, r_ready, w_nl, w_acc, w_print;
  logic [5:0] r_col, w_col;
  logic [4:0] r_row, w_row, w_row_nx;
`ifdef VGA_CONSOLE_TAB_EN
  logic [6:0] w_tab;
  assign w_tab = {1'b0, r_col[5:3], 3'b000} + 7'd8;
`endif
  assign w_acc = char_valid && r_ready;
  assign w_print = char_data >= 8'h20 && char_data <= 8'h7E;
  assign w_row_nx = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;
  assign char_ready = r_ready;
  assign vram_waddr = r_waddr;
  assign vram_wdata = r_wdata;
  assign vram_we = r_we;
  assign cur_col = r_col;
  assign cur_row = r_row;
  // r_addr always tracks the cursor cell (or the next cell to clear while clearing)
  always_comb begin
    w_state = r_state;
    w_addr = r_addr;
    w_cnt = r_cnt;
    w_col = r_col;
    w_row = r_row;
    w_we = 1'b0;
    w_waddr = r_waddr;
    w_wdata = r_wdata;
    w_nl = 1'b0;
    if (r_state != IDLE) begin
      w_we = 1'b1;
      w_waddr = r_addr;
      w_wdata = FILL;
      w_addr = r_addr + AW'(1);
      w_cnt = r_cnt + AW'(1);
      if (r_cnt == ((r_state == CLEAR) ? LAST_ALL : LAST_COL)) begin
        w_state = IDLE;
        w_cnt = '0;
        w_addr = (r_state == CLEAR) ? '0 : r_addr - LAST_COL;
        w_col = '0;
        w_row = (r_state == CLEAR) ? 5'd0 : r_row;
      end
    end else if (w_acc) begin
      if (w_print) begin
        w_we = 1'b1;
        w_waddr = r_addr;
        w_wdata = char_data;
        w_col = r_col + 6'd1;
        w_addr = r_addr + AW'(1);
        w_nl = (r_col == 6'(COLS - 1));
      end else if (char_data == 8'h0A) begin
        w_nl = 1'b1;
      end else if (char_data == 8'h0D) begin
        w_col = '0;
        w_addr = r_addr - AW'(r_col);
      end else if (char_data == 8'h08 && r_col != '0) begin
        w_we = 1'b1;
        w_waddr = r_addr - AW'(1);
        w_wdata = FILL;
        w_col = r_col - 6'd1;
        w_addr = r_addr - AW'(1);
      end else if (char_data == 8'h0C) begin
        w_state = CLEAR;
        w_cnt = '0;
        w_addr = '0;
      end
`ifdef VGA_CONSOLE_TAB_EN
      else if (char_data == 8'h09) begin
        w_nl = (w_tab >= 7'(COLS));
        w_col = w_tab[5:0];
        w_addr = r_addr + AW'(w_tab) - AW'(r_col);
      end
`endif
    end
    // newline (LF, autowrap, tab past the edge) enters and clears the next row
    if (w_nl) begin
      w_state = CLRLINE;
      w_cnt = '0;
      w_col = '0;
      w_row = w_row_nx;
      w_addr = AW'(w_row_nx) * AW'(COLS);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_addr <= '0;
      r_cnt <= '0;
      r_col <= '0;
      r_row <= '0;
      r_we <= 1'b0;
      r_waddr <= '0;
      r_wdata <= FILL;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr <= w_addr;
      r_cnt <= w_cnt;
      r_col <= w_col;
      r_row <= w_row;
      r_we <= w_we;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
      r_ready <= (w_state == IDLE);
    end
  end
endmodule

// File: tb/tb_vga_console_writer.sv
// tb_vga_console_writer: directed and random byte streams checked against a screen-image model.
module tb_vga_console_writer;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int N = COLS * ROWS;
  localparam logic [7:0] FILL = 8'h20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic char_ready, vram_we;
  logic [10:0] vram_waddr;
  logic [7:0] vram_wdata;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  typedef struct { int cyc; int a; int d; } wr_t;
  wr_t log_q[$];
  logic [7:0] vram [2048];
  logic [7:0] scr [N];
  int m_col, m_row;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int s_we, s_a, s_d;

  vga_console_writer dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vram_we) begin
      vram[vram_waddr] <= vram_wdata;
      log_q.push_back('{cyc, int'(vram_waddr), int'(vram_wdata)});
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) scr[m_row * COLS + i] = FILL;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) scr[i] = FILL;
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[m_row * COLS + m_col] = b;
      m_col++;
      if (m_col == COLS) model_newline();
    end else if (b == 8'h0A) model_newline();
    else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row * COLS + m_col] = FILL;
      end
    end else if (b == 8'h0C) model_clear();
`ifdef VGA_CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      if ((m_col / 8 + 1) * 8 >= COLS) model_newline();
      else m_col = (m_col / 8 + 1) * 8;
    end
`endif
  endfunction

  function automatic int screen_diff();
    int d = 0;
    for (int i = 0; i < N; i++) if (vram[i] !== scr[i]) d++;
    return d;
  endfunction

  // log entries first.. should be FILL at base.. on consecutive cycles
  function automatic int seq_err(input int first, input int base, input int cnt);
    int e = 0;
    for (int i = 0; i < cnt; i++) begin
      if (first + i >= log_q.size()) e++;
      else begin
        if (log_q[first + i].a != base + i || log_q[first + i].d != int'(FILL)) e++;
        if (i > 0 && log_q[first + i].cyc != log_q[first + i - 1].cyc + 1) e++;
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!char_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("idle_timeout", int'(char_ready), 1);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    char_valid = 1'b1;
    char_data = b;
    while (!char_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("send_timeout", int'(char_ready), 1);
    @(negedge clk);
    char_valid = 1'b0;
    s_we = int'(vram_we);
    s_a = int'(vram_waddr);
    s_d = int'(vram_wdata);
    model_apply(b);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, int'(cur_col), m_col);
    check({tag, "_row"}, int'(cur_row), m_row);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, n, r;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("rst_we", int'(vram_we), 0);
    check("rst_waddr", int'(vram_waddr), 0);
    check("rst_wdata", int'(vram_wdata), int'(FILL));
    check("rst_ready", int'(char_ready), 0);
    check("rst_col", int'(cur_col), 0);
    check("rst_row", int'(cur_row), 0);
    model_clear();
    log_q.delete();
    rst_n = 1'b1;
    wait_idle();
    check("clr_count", log_q.size(), N);
    check("clr_seq", seq_err(0, 0, N), 0);
    check("clr_ready", int'(char_ready), 1);
    check_cursor("clr");
    // back-to-back printables
    log_q.delete();
    send(8'h41);
    check("a_we", s_we, 1); check("a_addr", s_a, 0); check("a_data", s_d, 8'h41);
    check("a_ready", int'(char_ready), 1);
    send(8'h42);
    check("b_we", s_we, 1); check("b_addr", s_a, 1); check("b_data", s_d, 8'h42);
    check("b_ready", int'(char_ready), 1);
    check("b_col", int'(cur_col), 2);
    wait_idle();
    check("ab_count", log_q.size(), 2);
    if (log_q.size() == 2) check("ab_b2b", log_q[1].cyc - log_q[0].cyc, 1);
    // fill row 5 and autowrap
    send(8'h0D);
    check("cr_we", s_we, 0);
    check("cr_col", int'(cur_col), 0);
    repeat (5) begin send(8'h0A); wait_idle(); end
    check_cursor("row5");
    log_q.delete();
    repeat (COLS) send(8'h58);
    check("wrap_last_addr", s_a, 239);
    check("wrap_last_data", s_d, 8'h58);
    check("wrap_ready", int'(char_ready), 0);
    wait_idle();
    check("wrap_count", log_q.size(), 80);
    e = 0;
    for (int i = 0; i < 40 && i < log_q.size(); i++) begin
      if (log_q[i].a != 200 + i || log_q[i].d != 8'h58) e++;
      if (i > 0 && log_q[i].cyc != log_q[i - 1].cyc + 1) e++;
    end
    check("wrap_x_seq", e, 0);
    check("wrap_clr_seq", seq_err(40, 240, 40), 0);
    check_cursor("wrap");
    // LF on the last row wraps to row 0
    repeat (23) begin send(8'h0A); wait_idle(); end
    check("lf29_row", int'(cur_row), 29);
    log_q.delete();
    send(8'h0A);
    check("lf29_we", s_we, 0);
    wait_idle();
    check("lf29_count", log_q.size(), 40);
    check("lf29_seq", seq_err(0, 0, 40), 0);
    check_cursor("lf29");
    // backspace and ignored controls
    send(8'h0A); wait_idle();
    send(8'h0A); wait_idle();
    send(8'h61); send(8'h62); send(8'h63);
    check_cursor("bs_pre");
    send(8'h08);
    check("bs1_we", s_we, 1); check("bs1_addr", s_a, 82); check("bs1_data", s_d, int'(FILL));
    send(8'h08);
    check("bs2_we", s_we, 1); check("bs2_addr", s_a, 81);
    send(8'h08);
    check("bs3_addr", s_a, 80);
    send(8'h08);
    check("bs0_we", s_we, 0);
    check_cursor("bs0");
    send(8'h71);
    send(8'h0D);
    check("cr2_we", s_we, 0);
    check_cursor("cr2");
    send(8'h72);
    send(8'h07);
    check("bel_we", s_we, 0);
    check_cursor("bel");
    // tab near the right edge
    repeat (36) send(8'h54);
    check("tab_pre_col", int'(cur_col), 37);
    send(8'h09);
    check("tab_we", s_we, 0);
`ifdef VGA_CONSOLE_TAB_EN
    check("tab_ready", int'(char_ready), 0);
`else
    check("tab_ready", int'(char_ready), 1);
`endif
    wait_idle();
    check_cursor("tab");
    check("dir_screen", screen_diff(), 0);
    // random stream
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      b = r < 70 ? 8'($urandom_range(32, 126)) : r < 78 ? 8'h0A : r < 83 ? 8'h0D :
          r < 90 ? 8'h08 : r < 91 ? 8'h0C : r < 95 ? 8'h09 : 8'($urandom_range(0, 255));
      send(b);
      if (k % 25 == 24) begin
        wait_idle();
        check_cursor("rnd");
        check("rnd_screen", screen_diff(), 0);
      end
    end
    // reset in the middle of a clear
    send(8'h0C);
    n = 0;
    while (!(vram_we && vram_waddr == 11'd600) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach", int'(vram_we && vram_waddr == 11'd600), 1);
    rst_n = 1'b0;
    #1;
    check("abort_we", int'(vram_we), 0);
    check("abort_ready", int'(char_ready), 0);
    check("abort_waddr", int'(vram_waddr), 0);
    repeat (2) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    wait_idle();
    check("reclr_count", log_q.size(), N);
    check("reclr_seq", seq_err(0, 0, N), 0);
    check_cursor("reclr");
    check("reclr_screen", screen_diff(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
